// File: rtl/mc_core.sv
// Multi-cycle RV64I-subset core: shared req/ready memory port, register file, ALU,
// sequencing FSM, retired-instruction counter and illegal-opcode trap.
module mc_core #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_ifetch,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instret,
  output logic            halted
);

  localparam int unsigned RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0]   alu_q, alu_d, mdr_q, mdr_d, instret_q, instret_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]       ir_q, ir_d;
  logic              req_q, req_d, we_q, we_d, ifetch_q, ifetch_d, halted_q, halted_d;
  logic [XLEN-1:0]   rf_q [NREG];
  logic              rf_we;
  logic [RIDX_W-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  logic [6:0]        opcode_c, funct7_c;
  logic [2:0]        funct3_c;
  logic [RIDX_W-1:0] rs1_c, rs2_c, rd_c;
  logic [11:0]       imm_i_c, imm_s_c;
  logic [12:0]       imm_b_c;
  logic [XLEN-1:0]   imm_c, alu_c, pc_plus4_c;
  logic              legal_c, xfer_c;

  assign opcode_c   = ir_q[6:0];
  assign funct3_c   = ir_q[14:12];
  assign funct7_c   = ir_q[31:25];
  assign rs1_c      = RIDX_W'(32'(ir_q[19:15]) % NREG);
  assign rs2_c      = RIDX_W'(32'(ir_q[24:20]) % NREG);
  assign rd_c       = RIDX_W'(32'(ir_q[11:7]) % NREG);
  assign imm_i_c    = ir_q[31:20];
  assign imm_s_c    = {ir_q[31:25], ir_q[11:7]};
  assign imm_b_c    = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign pc_plus4_c = pc_q + XLEN'(4);
  assign xfer_c     = req_q & mem_ready;

  // Decode: legality check and immediate format selection
  always_comb begin
    legal_c = 1'b0;
    imm_c   = {{(XLEN-12){imm_i_c[11]}}, imm_i_c};
    case (opcode_c)
      OP_R:   legal_c = ((funct3_c == 3'b000) && (funct7_c == 7'h00 || funct7_c == 7'h20)) ||
                        ((funct3_c == 3'b111 || funct3_c == 3'b110) && (funct7_c == 7'h00));
      OP_IMM: legal_c = (funct3_c == 3'b000);
      OP_LD:  legal_c = (funct3_c == 3'b011);
      OP_ST: begin
        legal_c = (funct3_c == 3'b011);
        imm_c   = {{(XLEN-12){imm_s_c[11]}}, imm_s_c};
      end
      OP_BR: begin
        legal_c = (funct3_c == 3'b000);
        imm_c   = {{(XLEN-13){imm_b_c[12]}}, imm_b_c};
      end
      default: legal_c = 1'b0;
    endcase
  end

  always_comb begin
    alu_c = a_q + imm_q;
    if (opcode_c == OP_R) begin
      case (funct3_c)
        3'b111:  alu_c = a_q & b_q;
        3'b110:  alu_c = a_q | b_q;
        default: alu_c = funct7_c[5] ? (a_q - b_q) : (a_q + b_q);
      endcase
    end
  end

  // Sequencing FSM; memory-port outputs are computed for the state being entered
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    instret_d = instret_q;
    halted_d  = halted_q;
    req_d     = req_q;
    we_d      = we_q;
    ifetch_d  = ifetch_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rf_we     = 1'b0;
    rf_waddr  = rd_c;
    rf_wdata  = alu_q;
    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          req_d    = 1'b1;
          ifetch_d = 1'b1;
          we_d     = 1'b0;
          addr_d   = pc_q;
        end else if (xfer_c) begin
          ir_d     = mem_rdata[31:0];
          req_d    = 1'b0;
          ifetch_d = 1'b0;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal_c) begin
          a_d     = rf_q[rs1_c];
          b_d     = rf_q[rs2_c];
          imm_d   = imm_c;
          state_d = S_EXEC;
        end else begin
          halted_d = 1'b1;
          state_d  = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_d = alu_c;
        if (opcode_c == OP_BR) begin
          pc_d      = (a_q == b_q) ? (pc_q + imm_q) : pc_plus4_c;
          instret_d = instret_q + XLEN'(1);
          req_d     = 1'b1;
          ifetch_d  = 1'b1;
          we_d      = 1'b0;
          addr_d    = pc_d;
          state_d   = S_FETCH;
        end else if (opcode_c == OP_LD || opcode_c == OP_ST) begin
          req_d    = 1'b1;
          ifetch_d = 1'b0;
          we_d     = (opcode_c == OP_ST);
          addr_d   = alu_c;
          wdata_d  = b_q;
          state_d  = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (xfer_c) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (opcode_c == OP_ST) begin
            pc_d      = pc_plus4_c;
            instret_d = instret_q + XLEN'(1);
            req_d     = 1'b1;
            ifetch_d  = 1'b1;
            addr_d    = pc_plus4_c;
            state_d   = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = (rd_c != '0);
        rf_wdata  = (opcode_c == OP_LD) ? mdr_q : alu_q;
        pc_d      = pc_plus4_c;
        instret_d = instret_q + XLEN'(1);
        req_d     = 1'b1;
        ifetch_d  = 1'b1;
        we_d      = 1'b0;
        addr_d    = pc_plus4_c;
        state_d   = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: begin
        halted_d = 1'b1;
        state_d  = S_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      ifetch_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
      req_q     <= req_d;
      we_q      <= we_d;
      ifetch_q  <= ifetch_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_ifetch = ifetch_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign pc_out     = pc_q;
  assign instret    = instret_q;
  assign halted     = halted_q;

endmodule
